// File: rtl/la_ctrl_pkg.sv
// Shared types and defaults for the logic-analyzer capture sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package la_ctrl_pkg;

    // Fixed encodings; the debug readout decodes state_o with these values.
    typedef enum logic [2:0] {
        S_LOCK     = 3'd0,
        S_RST      = 3'd1,
        S_IDLE     = 3'd2,
        S_START    = 3'd3,
        S_ARMWAIT  = 3'd4,
        S_TRIGWAIT = 3'd5,
        S_DONE     = 3'd6
    } la_state_e;

    localparam int unsigned LOCK_FILT_DEF  = 16;
    localparam int unsigned RST_CYCLES_DEF = 15;

endpackage

// File: rtl/la_qual_gen.sv
// Capture qualifier divider: cqual is high one cycle in every qdiv+1.
// Latency: first strobe qdiv+1 cycles after en rises; qdiv is re-sampled on each reload.
// Backpressure: none; free-running while en is high, held at zero otherwise.
module la_qual_gen #(
    parameter int unsigned QDIV_W = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              en,
    input  logic [QDIV_W-1:0] qdiv,
    output logic              cqual
);

    logic [QDIV_W-1:0] cnt_q, cnt_d;
    logic              cqual_q;

    // Down-counter: reload from qdiv at zero, park at zero while disabled.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == '0) ? qdiv : cnt_q - 1'b1;
        end
    end

    // Strobe is registered from the next count so it lines up with the counter at zero.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q   <= '0;
            cqual_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cqual_q <= en && (cnt_d == '0);
        end
    end

    assign cqual = cqual_q;

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: lock filter, analyzer reset, qualifier, start/arm/trigger handshake.
// Latency: la_sys_run one cycle after run_req is sampled in S_IDLE; all outputs registered.
// Backpressure: run_req outside S_IDLE is dropped; optional arm watchdog via LA_CAPTURE_CTRL_TIMEOUT_EN.
module la_capture_ctrl
    import la_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_FILT  = LOCK_FILT_DEF,
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
    parameter int unsigned QDIV_W     = 16,
    parameter int unsigned TIMEOUT_W  = 24
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              pll_lock,
    input  logic [QDIV_W-1:0] qdiv,
    input  logic              run_req,
    input  logic              la_armed,
    input  logic              la_triggered,
    output logic              la_rst_l,
    output logic              la_cqual,
    output logic              la_sys_run,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state_o
);

    // One shared counter serves the lock filter and the reset hold; it clears on every state change.
    localparam int unsigned CNT_MAXV = (LOCK_FILT > RST_CYCLES) ? LOCK_FILT : RST_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAXV + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);

    la_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             la_rst_l_q, sys_run_q, busy_q, done_q;
    logic             wd_expire;

`ifdef LA_CAPTURE_CTRL_TIMEOUT_EN
    // Expiry fires on the cycle the watchdog count steps to all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 timeout_q;

    // Watchdog counts cycles spent in S_ARMWAIT, saturating, cleared in any other state.
    always_comb begin
        wd_d = '0;
        if (state_q == S_ARMWAIT) begin
            wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        end
    end

    assign wd_expire = (state_q == S_ARMWAIT) && (wd_q == WD_LAST);

    // Timeout pulse only when the expiry actually wins the transition.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= wd_expire && (state_d == S_RST);
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Next-state logic; lock loss overrides everything at the end.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_LOCK: begin
                if (pll_lock) begin
                    if (cnt_q >= LOCK_LAST) state_d = S_RST;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_RST: begin
                if (cnt_q >= RST_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_IDLE:     if (run_req) state_d = S_START;
            S_START:    state_d = S_ARMWAIT;
            S_ARMWAIT: begin
                if (la_triggered)   state_d = S_DONE;
                else if (la_armed)  state_d = S_TRIGWAIT;
                else if (wd_expire) state_d = S_RST;
            end
            S_TRIGWAIT: if (la_triggered) state_d = S_DONE;
            S_DONE:     if (!la_armed)    state_d = S_IDLE;
            default:    state_d = S_LOCK;
        endcase
        if ((state_q != S_LOCK) && !pll_lock) begin
            state_d = S_LOCK;
            cnt_d   = '0;
        end
    end

    // State, counter and outputs registered from the next state so they agree with state_o.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= S_LOCK;
            cnt_q      <= '0;
            la_rst_l_q <= 1'b0;
            sys_run_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            la_rst_l_q <= (state_d != S_LOCK) && (state_d != S_RST);
            sys_run_q  <= (state_d == S_START);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_q == S_DONE) && (state_d == S_IDLE);
        end
    end

    la_qual_gen #(
        .QDIV_W (QDIV_W)
    ) u_qual (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (la_rst_l_q),
        .qdiv  (qdiv),
        .cqual (la_cqual)
    );

    assign la_rst_l   = la_rst_l_q;
    assign la_sys_run = sys_run_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with a queue of expected state transitions.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_la_capture_ctrl;
    import la_ctrl_pkg::*;

    localparam int unsigned QDIV_W = 16;
`ifdef LA_CAPTURE_CTRL_TIMEOUT_EN
    localparam int unsigned TW = 4;
`else
    localparam int unsigned TW = 24;
`endif

    logic              clk;
    logic              rst_l;
    logic              pll_lock;
    logic [QDIV_W-1:0] qdiv;
    logic              run_req;
    logic              la_armed;
    logic              la_triggered;
    logic              la_rst_l;
    logic              la_cqual;
    logic              la_sys_run;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [2:0]        state_o;

    la_capture_ctrl #(
        .LOCK_FILT  (16),
        .RST_CYCLES (15),
        .QDIV_W     (QDIV_W),
        .TIMEOUT_W  (TW)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .pll_lock     (pll_lock),
        .qdiv         (qdiv),
        .run_req      (run_req),
        .la_armed     (la_armed),
        .la_triggered (la_triggered),
        .la_rst_l     (la_rst_l),
        .la_cqual     (la_cqual),
        .la_sys_run   (la_sys_run),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         errors;
    int         sys_runs;
    int         dones;
    int         touts;
    int         n;
    int         base_runs;
    int         base_dones;
    bit         track;
    logic [2:0] prev_state;
    logic [2:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; tally pulses and score state changes against the queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (la_sys_run === 1'b1) sys_runs++;
        if (done === 1'b1)       dones++;
        if (timeout === 1'b1)    touts++;
        if (state_o !== prev_state) begin
            if (track) begin
                if (exp_q.size() == 0) chk("state_unexpected", 32'(state_o), 32'(prev_state));
                else                   chk("state_seq", 32'(state_o), 32'(exp_q.pop_front()));
            end
            prev_state = state_o;
        end
    endtask

    task automatic wait_state(input logic [2:0] want, input int budget, input string tag);
        int k;
        k = 0;
        while (state_o !== want && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(state_o), 32'(want));
    endtask

    initial begin
        #500000;
        $display("FAIL tb_time_limit: observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        checks = 0; errors = 0; sys_runs = 0; dones = 0; touts = 0;
        track = 1'b0; prev_state = 3'd0;
        rst_l = 1'b0; pll_lock = 1'b0; qdiv = 16'd3;
        run_req = 1'b0; la_armed = 1'b0; la_triggered = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_la_rst_l", 32'(la_rst_l), 0);
        chk("rst_cqual",    32'(la_cqual), 0);
        chk("rst_sys_run",  32'(la_sys_run), 0);
        chk("rst_busy",     32'(busy), 1);
        chk("rst_done",     32'(done), 0);
        chk("rst_timeout",  32'(timeout), 0);
        chk("rst_state",    32'(state_o), 32'(S_LOCK));

        // Lock filter: unlocked idle, a 10-cycle lock with a 1-cycle dropout, then stable lock
        rst_l = 1'b1;
        repeat (3) tick();
        pll_lock = 1'b1;
        repeat (10) tick();
        pll_lock = 1'b0;
        tick();
        chk("lock_glitch_hold", 32'(state_o), 32'(S_LOCK));
        pll_lock = 1'b1;
        n = 0;
        while (la_rst_l !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("lock_to_rst_release", n, 31);
        chk("idle_after_rst", 32'(state_o), 32'(S_IDLE));
        chk("idle_not_busy", 32'(busy), 0);

        // Qualifier: qdiv=3 gives 1-in-4; then qdiv=0 gives constant high
        n = 0;
        while (la_cqual !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("cqual_first", n, 4);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("cqual_div4", 32'(la_cqual), ((k % 4) == 0) ? 1 : 0);
        end
        qdiv = 16'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("cqual_div1", 32'(la_cqual), 1);
        end
        qdiv = 16'd3;

        // Normal capture; run_req held into S_START must be ignored
        track = 1'b1; prev_state = state_o;
        base_runs = sys_runs; base_dones = dones;
        exp_q.push_back(S_START); exp_q.push_back(S_ARMWAIT); exp_q.push_back(S_TRIGWAIT);
        exp_q.push_back(S_DONE);  exp_q.push_back(S_IDLE);
        run_req = 1'b1;
        tick();
        chk("sys_run_next", 32'(la_sys_run), 1);
        tick();
        run_req = 1'b0;
        tick();
        la_armed = 1'b1;
        repeat (17) tick();
        la_triggered = 1'b1;
        wait_state(S_DONE, 10, "cap_done_state");
        la_armed = 1'b0;
        wait_state(S_IDLE, 10, "cap_idle_state");
        chk("cap_done_with_idle", 32'(done), 1);
        la_triggered = 1'b0;
        tick();
        chk("cap_done_one_cycle", 32'(done), 0);
        chk("cap_sys_run_count", sys_runs - base_runs, 1);
        chk("cap_done_count", dones - base_dones, 1);
        chk("cap_seq_drained", exp_q.size(), 0);

        // Early trigger: S_ARMWAIT straight to S_DONE
        base_dones = dones;
        exp_q.push_back(S_START); exp_q.push_back(S_ARMWAIT);
        exp_q.push_back(S_DONE);  exp_q.push_back(S_IDLE);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        wait_state(S_ARMWAIT, 5, "early_armwait");
        la_triggered = 1'b1;
        tick();
        chk("early_direct_done", 32'(state_o), 32'(S_DONE));
        la_triggered = 1'b0;
        wait_state(S_IDLE, 5, "early_idle");
        chk("early_done_count", dones - base_dones, 1);
        chk("early_seq_drained", exp_q.size(), 0);

        // Lock loss in S_TRIGWAIT
        base_dones = dones;
        exp_q.push_back(S_START); exp_q.push_back(S_ARMWAIT);
        exp_q.push_back(S_TRIGWAIT); exp_q.push_back(S_LOCK);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        wait_state(S_ARMWAIT, 5, "ll_armwait");
        la_armed = 1'b1;
        wait_state(S_TRIGWAIT, 5, "ll_trigwait");
        pll_lock = 1'b0;
        la_triggered = 1'b1;
        tick();
        chk("ll_state", 32'(state_o), 32'(S_LOCK));
        chk("ll_la_rst_l", 32'(la_rst_l), 0);
        chk("ll_no_done", 32'(done), 0);
        chk("ll_busy", 32'(busy), 1);
        chk("ll_seq_drained", exp_q.size(), 0);
        track = 1'b0;
        la_triggered = 1'b0;
        la_armed = 1'b0;
        pll_lock = 1'b1;
        wait_state(S_IDLE, 100, "ll_relock_idle");
        chk("ll_done_count", dones - base_dones, 0);

`ifdef LA_CAPTURE_CTRL_TIMEOUT_EN
        // Watchdog: la_armed never rises
        track = 1'b1; prev_state = state_o;
        exp_q.push_back(S_START); exp_q.push_back(S_ARMWAIT);
        exp_q.push_back(S_RST);   exp_q.push_back(S_IDLE);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        wait_state(S_ARMWAIT, 5, "wd_armwait");
        n = 0;
        while (timeout !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, 15);
        chk("wd_state_rst", 32'(state_o), 32'(S_RST));
        chk("wd_la_rst_l", 32'(la_rst_l), 0);
        tick();
        chk("wd_pulse_one_cycle", 32'(timeout), 0);
        wait_state(S_IDLE, 40, "wd_idle");
        chk("wd_seq_drained", exp_q.size(), 0);
        chk("wd_timeout_count", touts, 1);
`else
        chk("timeout_tied_low", touts, 0);
        chk("timeout_now", 32'(timeout), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Capture sequencer for the on-chip logic analyzer. Filters PLL lock, generates the analyzer's power-on reset, divides the clock into the capture qualifier strobe, and runs a start/arm/trigger handshake with the analyzer core so user logic can request repeated captures with one pulse. Sits between the PLL and the analyzer instance in the top level, in the PLL output clock domain.

## Interface
- LOCK_FILT, 16: consecutive cycles `pll_lock` must be high before leaving S_LOCK (≥1).
- RST_CYCLES, 15: cycles `la_rst_l` is held low in S_RST (≥1).
- QDIV_W, 16: width of the qualifier divider.
- TIMEOUT_W, 24: width of the arm-wait watchdog counter.
- clk  in  1  system clock (PLL global output).
- rst_l  in  1  asynchronous, active-low reset.
- pll_lock  in  1  raw PLL LOCK.
- qdiv  in  QDIV_W  qualifier period minus 1; sampled on each reload.
- run_req  in  1  capture request; level sampled in S_IDLE only.
- la_armed  in  1  analyzer armed status.
- la_triggered  in  1  analyzer triggered status.
- la_rst_l  out  1  analyzer reset, active-low.
- la_cqual  out  1  clock-qualifier strobe to the analyzer.
- la_sys_run  out  1  one-cycle start pulse to the analyzer.
- busy  out  1  high in every state except S_IDLE.
- done  out  1  one-cycle pulse when a capture completes.
- timeout  out  1  one-cycle pulse on arm-wait watchdog expiry.
- state_o  out  3  current state encoding.

## Operation
- States: S_LOCK, S_RST, S_IDLE, S_START, S_ARMWAIT, S_TRIGWAIT, S_DONE.
- S_LOCK: the filter counter increments while `pll_lock`=1 and clears when it is 0. At LOCK_FILT, go to S_RST.
- S_RST: `la_rst_l`=0 for RST_CYCLES cycles, then go to S_IDLE. `la_rst_l` is 0 in S_LOCK and S_RST and 1 in all other states.
- S_IDLE: if `run_req`=1, go to S_START.
- S_START: `la_sys_run`=1 for exactly one cycle, then go to S_ARMWAIT.
- S_ARMWAIT: if `la_triggered`=1, go to S_DONE; this check has priority over `la_armed`. Otherwise, if `la_armed`=1, go to S_TRIGWAIT.
- S_TRIGWAIT: wait indefinitely for `la_triggered`=1, then go to S_DONE.
- S_DONE: wait for `la_armed`=0 (upload finished). Then pulse `done` and go to S_IDLE.
- Lock loss: `pll_lock`=0 in any state other than S_LOCK sends the FSM to S_LOCK on the next edge. This overrides all other transitions; any pending `done` or `timeout` pulse is suppressed.
- `run_req` outside S_IDLE is ignored, not queued.
- Qualifier: a down-counter reloads from `qdiv` when it reaches 0, and `la_cqual`=(counter==0).
  - `qdiv`=0 gives `la_cqual` constantly 1.
  - The counter is held at 0 with `la_cqual`=0 while `la_rst_l`=0.
  - The counter free-runs from S_IDLE onward.
- Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Reset values: state S_LOCK, `la_rst_l`=0, `la_cqual`=0, `la_sys_run`=0, `busy`=1, `done`=0, `timeout`=0, `state_o`=S_LOCK encoding.
- From reset release with `pll_lock` held high: `la_rst_l` rises LOCK_FILT+RST_CYCLES cycles later.
- From `run_req` sampled in S_IDLE: `la_sys_run` is high on the next cycle.
- First `la_cqual` pulse after `la_rst_l` rises: at cycle qdiv+1.
- `done` asserts in the cycle the FSM enters S_IDLE.

## Configuration
- LA_CAPTURE_CTRL_TIMEOUT_EN defined:
  - The watchdog counts cycles in S_ARMWAIT.
  - At 2^TIMEOUT_W−1 it pulses `timeout` and sends the FSM to S_RST to re-reset the analyzer.
  - The counter clears on entry to S_ARMWAIT.
- Undefined: S_ARMWAIT waits forever, `timeout` is tied to 0, and no watchdog logic is built.

## Structure
- Package la_ctrl_pkg holds:
  - the 3-bit state enum with fixed encodings S_LOCK=0 through S_DONE=6, shared with the debug readout;
  - default constants for LOCK_FILT and RST_CYCLES.
- Sub-module la_qual_gen contains the qualifier divider. Ports: clk, rst_l, en, qdiv, cqual.

## Test plan
- Lock filter: `pll_lock` high 10 cycles, low 1 cycle, then high -> `la_rst_l` rises exactly 16+15 cycles after the final rise.
- Capture: in S_IDLE, pulse `run_req`; raise `la_armed` 3 cycles later, `la_triggered` 20 cycles later, then drop `la_armed` -> one `la_sys_run` pulse, `state_o` sequence 3,4,5,6,2, one `done` pulse.
- Early trigger: in S_ARMWAIT, `la_triggered`=1 while `la_armed`=0 -> direct transition to S_DONE.
- Qualifier: `qdiv`=3 -> `la_cqual` high 1 cycle in every 4. `qdiv`=0 -> `la_cqual` constantly high.
- Lock loss: drop `pll_lock` in S_TRIGWAIT -> S_LOCK next cycle, `la_rst_l`=0, no `done` pulse.
- Watchdog (macro defined, TIMEOUT_W=4): hold `la_armed`=0 -> `timeout` pulses after 15 cycles in S_ARMWAIT, then the FSM enters S_RST.
